// File: rtl/piano_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piano_pkg
//  Description : Shared constants and types for the keyboard-to-voice path:
//                event message layout, allocator FSM states, note event.
//  Revision    : 1.0  initial release
// ============================================================================
package piano_pkg;

  localparam int MSG_ON_BIT = 7;
  localparam int NOTE_W     = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
  } note_event_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Two-flop synchronizer for an asynchronous level followed by
//                a single-cycle rising-edge pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // A long high level produces a single pulse; a low sample re-arms it.
  assign rise = s2_q & ~s3_q;

endmodule
`default_nettype wire

// File: rtl/voice_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : voice_alloc
//  Description : Polyphonic voice allocator. Takes note-on/note-off events
//                from the keyboard scanner, assigns them to a voice pool and
//                steals the least-recently-assigned voice when full.
//  Revision    : 1.0  initial release
// ============================================================================
module voice_alloc
  import piano_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int RANK_W = $clog2(VOICES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_msg,
  input  logic [7:0]               msg,
  output logic [VOICES-1:0]        voice_gate,
  output logic [NOTE_W*VOICES-1:0] voice_note,
  output logic [VOICES-1:0]        voice_trig,
  output logic                     busy,
  output logic                     dropped
);

  localparam logic [RANK_W-1:0] c_last_idx = RANK_W'(VOICES - 1);

  logic                rise;
  logic                consume;

  state_t              state_q;
  state_t              state_d;

  logic                pend_valid_q;
  note_event_t         pend_msg_q;
  logic                dropped_q;

  note_event_t         work_q;
  logic [RANK_W-1:0]   idx_q;
  logic                hit_found_q;
  logic [RANK_W-1:0]   hit_idx_q;
  logic                free_found_q;
  logic [RANK_W-1:0]   free_idx_q;
  logic [RANK_W-1:0]   old_idx_q;
  logic [RANK_W-1:0]   tgt_idx;

  logic [VOICES-1:0]   gate_q;
  logic [NOTE_W-1:0]   note_q [VOICES];
  logic [RANK_W-1:0]   rank_q [VOICES];
  logic [VOICES-1:0]   trig_q;

  sync_edge u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (clk_msg),
    .rise (rise)
  );

  // The slot is freed in the same cycle IDLE moves it to the working register.
  assign consume = (state_q == IDLE) && pend_valid_q;

  // Single-entry pending slot; a second event arriving while it is occupied is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_msg_q   <= '0;
      dropped_q    <= 1'b0;
    end else begin
      dropped_q <= 1'b0;
      if (rise) begin
        if (pend_valid_q && !consume) begin
          dropped_q <= 1'b1;
        end else begin
          pend_valid_q <= 1'b1;
          pend_msg_q   <= '{on: msg[MSG_ON_BIT], note: msg[NOTE_W-1:0]};
        end
      end else if (consume) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: one cycle per voice in SCAN, then a single COMMIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_valid_q) state_d = SCAN;
      SCAN:    if (idx_q == c_last_idx) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Scan bookkeeping: lowest matching held voice, lowest free voice, oldest voice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q       <= '0;
      idx_q        <= '0;
      hit_found_q  <= 1'b0;
      hit_idx_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      old_idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_valid_q) begin
            work_q       <= pend_msg_q;
            idx_q        <= '0;
            hit_found_q  <= 1'b0;
            free_found_q <= 1'b0;
          end
        end
        SCAN: begin
          idx_q <= idx_q + 1'b1;
          if (!hit_found_q && gate_q[idx_q] && (note_q[idx_q] == work_q.note)) begin
            hit_found_q <= 1'b1;
            hit_idx_q   <= idx_q;
          end
          if (!free_found_q && !gate_q[idx_q]) begin
            free_found_q <= 1'b1;
            free_idx_q   <= idx_q;
          end
          if (rank_q[idx_q] == c_last_idx) begin
            old_idx_q <= idx_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Note-on target priority: retrigger a held match, else a free voice, else steal.
  always_comb begin
    tgt_idx = old_idx_q;
    if (hit_found_q) begin
      tgt_idx = hit_idx_q;
    end else if (free_found_q) begin
      tgt_idx = free_idx_q;
    end
  end

  // Voice state and LRU ranks change only in COMMIT, so SCAN sees a stable snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_q <= '0;
      trig_q <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        rank_q[i] <= RANK_W'(i);
      end
    end else begin
      trig_q <= '0;
      if (state_q == COMMIT) begin
        if (work_q.on) begin
          gate_q[tgt_idx] <= 1'b1;
          note_q[tgt_idx] <= work_q.note;
          trig_q[tgt_idx] <= 1'b1;
          // Voices younger than the target age by one; the target becomes youngest.
          for (int v = 0; v < VOICES; v++) begin
            if (rank_q[v] < rank_q[tgt_idx]) begin
              rank_q[v] <= rank_q[v] + 1'b1;
            end
          end
          rank_q[tgt_idx] <= '0;
        end else if (hit_found_q) begin
          gate_q[hit_idx_q] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_note_out
    assign voice_note[NOTE_W*g +: NOTE_W] = note_q[g];
  end

  assign voice_gate = gate_q;
  assign voice_trig = trig_q;
  assign dropped    = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_alloc
//  Description : Directed self-checking bench for voice_alloc (4 voices).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_voice_alloc;

  localparam int VOICES = 4;

  logic                clk;
  logic                rst;
  logic                clk_msg;
  logic [7:0]          msg;
  logic [VOICES-1:0]   voice_gate;
  logic [7*VOICES-1:0] voice_note;
  logic [VOICES-1:0]   voice_trig;
  logic                busy;
  logic                dropped;

  int n_checks;
  int n_fail;
  int trig_tot [VOICES];
  int drop_tot;

  voice_alloc #(.VOICES(VOICES)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_msg    (clk_msg),
    .msg        (msg),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .voice_trig (voice_trig),
    .busy       (busy),
    .dropped    (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running pulse counters sampled on the falling edge.
  initial begin
    for (int v = 0; v < VOICES; v++) trig_tot[v] = 0;
    drop_tot = 0;
    forever begin
      @(negedge clk);
      for (int v = 0; v < VOICES; v++) if (voice_trig[v] === 1'b1) trig_tot[v]++;
      if (dropped === 1'b1) drop_tot++;
    end
  end

  function automatic logic [6:0] note_of(input int v);
    return voice_note[7*v +: 7];
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    clk_msg = 1'b0;
    msg     = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One strobe, then enough cycles for the event to commit and settle.
  task automatic send(input logic [7:0] m);
    msg     = m;
    clk_msg = 1'b1;
    @(negedge clk);
    clk_msg = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (voice_gate !== 4'h0) begin n_fail++; $display("FAIL reset_gate got=%0h exp=0", voice_gate); end
    n_checks++; if (voice_note !== 28'h0) begin n_fail++; $display("FAIL reset_note got=%0h exp=0", voice_note); end
    n_checks++; if (voice_trig !== 4'h0) begin n_fail++; $display("FAIL reset_trig got=%0h exp=0", voice_trig); end
    n_checks++; if ({busy, dropped} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_dropped got=%b exp=00", {busy, dropped}); end
  endtask

  task automatic test_single_on();
    int   first_k;
    int   pulses;
    logic busy3, busy4, busy9, gate8, gate9;
    do_reset();
    first_k = -1;
    pulses  = 0;
    busy3 = 1'bx; busy4 = 1'bx; busy9 = 1'bx; gate8 = 1'bx; gate9 = 1'bx;
    msg     = {1'b1, 7'd60};
    clk_msg = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) clk_msg = 1'b0;
      if (voice_trig[0] === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (k == 3) busy3 = busy;
      if (k == 4) busy4 = busy;
      if (k == 9) busy9 = busy;
      if (k == 8) gate8 = voice_gate[0];
      if (k == 9) gate9 = voice_gate[0];
    end
    n_checks++; if (first_k !== 9) begin n_fail++; $display("FAIL on_trig_cycle got=%0d exp=9", first_k); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL on_trig_count got=%0d exp=1", pulses); end
    n_checks++; if ({busy3, busy4, busy9} !== 3'b010) begin n_fail++; $display("FAIL on_busy_window got=%b exp=010", {busy3, busy4, busy9}); end
    n_checks++; if ({gate8, gate9} !== 2'b01) begin n_fail++; $display("FAIL on_gate_timing got=%b exp=01", {gate8, gate9}); end
    n_checks++; if (voice_gate !== 4'b0001) begin n_fail++; $display("FAIL on_gate got=%b exp=0001", voice_gate); end
    n_checks++; if (note_of(0) !== 7'd60) begin n_fail++; $display("FAIL on_note got=%0d exp=60", note_of(0)); end
  endtask

  task automatic test_steal_and_stale();
    int base0, base_all;
    do_reset();
    base0 = trig_tot[0];
    send({1'b1, 7'd60});
    send({1'b1, 7'd62});
    send({1'b1, 7'd64});
    send({1'b1, 7'd65});
    n_checks++; if (voice_gate !== 4'hF) begin n_fail++; $display("FAIL fill_gate got=%b exp=1111", voice_gate); end
    send({1'b1, 7'd67});
    n_checks++; if ({note_of(0), note_of(1), note_of(2), note_of(3)} !== {7'd67, 7'd62, 7'd64, 7'd65})
      begin n_fail++; $display("FAIL steal_notes got=%0d,%0d,%0d,%0d exp=67,62,64,65", note_of(0), note_of(1), note_of(2), note_of(3)); end
    n_checks++; if (trig_tot[0] - base0 !== 2) begin n_fail++; $display("FAIL steal_trig0 got=%0d exp=2", trig_tot[0] - base0); end
    // Stale note-off for the stolen note must change nothing.
    base_all = trig_tot[0] + trig_tot[1] + trig_tot[2] + trig_tot[3];
    send({1'b0, 7'd60});
    n_checks++; if (voice_gate !== 4'hF) begin n_fail++; $display("FAIL stale_gate got=%b exp=1111", voice_gate); end
    n_checks++; if (note_of(0) !== 7'd67) begin n_fail++; $display("FAIL stale_note got=%0d exp=67", note_of(0)); end
    n_checks++; if (trig_tot[0] + trig_tot[1] + trig_tot[2] + trig_tot[3] - base_all !== 0)
      begin n_fail++; $display("FAIL stale_trig got=%0d exp=0", trig_tot[0] + trig_tot[1] + trig_tot[2] + trig_tot[3] - base_all); end
    // Ranks v0=0 v3=1 v2=2 v1=3 imply further steals hit v1, v2, v3, v0 in turn.
    send({1'b1, 7'd69});
    n_checks++; if (note_of(1) !== 7'd69) begin n_fail++; $display("FAIL rank_steal1 got=%0d exp=69", note_of(1)); end
    send({1'b1, 7'd71});
    n_checks++; if (note_of(2) !== 7'd71) begin n_fail++; $display("FAIL rank_steal2 got=%0d exp=71", note_of(2)); end
    send({1'b1, 7'd72});
    n_checks++; if (note_of(3) !== 7'd72) begin n_fail++; $display("FAIL rank_steal3 got=%0d exp=72", note_of(3)); end
    send({1'b1, 7'd74});
    n_checks++; if (note_of(0) !== 7'd74) begin n_fail++; $display("FAIL rank_steal0 got=%0d exp=74", note_of(0)); end
  endtask

  task automatic test_retrig_and_off();
    int b0, b1;
    do_reset();
    b0 = trig_tot[0];
    b1 = trig_tot[1] + trig_tot[2] + trig_tot[3];
    send({1'b1, 7'd60});
    send({1'b1, 7'd60});
    n_checks++; if (trig_tot[0] - b0 !== 2) begin n_fail++; $display("FAIL retrig_count got=%0d exp=2", trig_tot[0] - b0); end
    n_checks++; if (trig_tot[1] + trig_tot[2] + trig_tot[3] - b1 !== 0) begin n_fail++; $display("FAIL retrig_other got=%0d exp=0", trig_tot[1] + trig_tot[2] + trig_tot[3] - b1); end
    n_checks++; if (voice_gate !== 4'b0001) begin n_fail++; $display("FAIL retrig_gate got=%b exp=0001", voice_gate); end
    send({1'b0, 7'd60});
    n_checks++; if (voice_gate !== 4'b0000) begin n_fail++; $display("FAIL off_gate got=%b exp=0000", voice_gate); end
    n_checks++; if (note_of(0) !== 7'd60) begin n_fail++; $display("FAIL off_note got=%0d exp=60", note_of(0)); end
    n_checks++; if (trig_tot[0] - b0 !== 2) begin n_fail++; $display("FAIL off_trig got=%0d exp=2", trig_tot[0] - b0); end
  endtask

  task automatic test_overflow();
    int d0;
    logic [7:0] seq [3];
    do_reset();
    seq[0] = {1'b1, 7'd50};
    seq[1] = {1'b1, 7'd52};
    seq[2] = {1'b1, 7'd54};
    d0 = drop_tot;
    for (int e = 0; e < 3; e++) begin
      msg     = seq[e];
      clk_msg = 1'b1;
      @(negedge clk);
      clk_msg = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    n_checks++; if (drop_tot - d0 !== 1) begin n_fail++; $display("FAIL ovf_dropped got=%0d exp=1", drop_tot - d0); end
    n_checks++; if (voice_gate !== 4'b0011) begin n_fail++; $display("FAIL ovf_gate got=%b exp=0011", voice_gate); end
    n_checks++; if ({note_of(0), note_of(1)} !== {7'd50, 7'd52})
      begin n_fail++; $display("FAIL ovf_order got=%0d,%0d exp=50,52", note_of(0), note_of(1)); end
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    seen    = 1'b0;
    msg     = {1'b1, 7'd56};
    clk_msg = 1'b1;
    @(negedge clk);
    clk_msg = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_busy_timeout got=0 exp=1"); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({voice_gate, voice_trig, busy, dropped} !== 10'h0)
      begin n_fail++; $display("FAIL mid_reset_ctl got=%b exp=0", {voice_gate, voice_trig, busy, dropped}); end
    n_checks++; if (voice_note !== 28'h0) begin n_fail++; $display("FAIL mid_reset_note got=%0h exp=0", voice_note); end
    rst = 1'b0;
    @(negedge clk);
    send({1'b1, 7'd48});
    n_checks++; if (voice_gate !== 4'b0001) begin n_fail++; $display("FAIL post_gate got=%b exp=0001", voice_gate); end
    n_checks++; if (note_of(0) !== 7'd48) begin n_fail++; $display("FAIL post_note got=%0d exp=48", note_of(0)); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clk_msg  = 1'b0;
    msg      = 8'h00;
    test_reset();
    test_single_on();
    test_steal_and_stale();
    test_retrig_and_off();
    test_overflow();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/voice_alloc.md
# voice_alloc

Polyphonic voice allocator sitting directly downstream of the keyboard scanner. Consumes its note-on/note-off event stream (`clk_msg` strobe plus 8-bit `msg`) and assigns held notes to a fixed pool of synthesis voices. Publishes per-voice gate, note number and retrigger pulse to the tone generators. Uses least-recently-assigned stealing when all voices are busy.

## Interface

Parameters:
- `VOICES`, 4: number of voices, power of two, 2..8.
- `RANK_W`, $clog2(VOICES): width of per-voice LRU rank.

Ports:
- `clk`, input, 1: system clock; the single clock of the block.
- `rst`, input, 1: reset, asynchronous, active-high.
- `clk_msg`, input, 1: event strobe from the scanner. Produced on a divided clock, so it is treated as asynchronous.
- `msg`, input, 8: event. Bit 7 = 1 for note-on, 0 for note-off. Bits 6:0 = MIDI note. Stable for at least 4 `clk` cycles around the `clk_msg` rise.
- `voice_gate`, output, VOICES: bit i high while voice i holds a note.
- `voice_note`, output, 7*VOICES: note of voice i in bits [7i+6:7i]. Holds its last value after gate falls.
- `voice_trig`, output, VOICES: 1-cycle pulse when voice i is (re)assigned a note-on.
- `busy`, output, 1: high while the FSM is not IDLE.
- `dropped`, output, 1: 1-cycle pulse when an event is lost because the pending slot is full.

## Operation

- **Input path**
  - `clk_msg` passes through a 2-flop synchronizer and a rising-edge detector.
  - On a detected edge, `msg` is captured into the pending slot (`pend_valid`, `pend_msg`).
  - If `pend_valid` is already set and not being consumed that cycle, the new event is discarded and `dropped` pulses.
- **FSM** (states IDLE, SCAN, COMMIT):
  - IDLE: if `pend_valid`, move `pend_msg` to the working register, clear `pend_valid`, set `idx` = 0, go to SCAN.
  - SCAN: one voice per cycle, `idx` 0..VOICES-1. Records:
    - `hit`: the lowest voice with gate = 1 and note == event note.
    - `free`: the lowest voice with gate = 0.
    - `oldest`: the voice with rank == VOICES-1.
    - After `idx` == VOICES-1, go to COMMIT.
  - COMMIT: apply the event (rules below), then return to IDLE. An event captured during SCAN or COMMIT is processed next, in arrival order.
- **Note-on target selection**, in priority order: `hit` (retrigger, note unchanged), then `free`, then `oldest` (steal). The target gets gate = 1, note = event note and a trig pulse.
- **LRU ranks**
  - On every note-on, the target's rank becomes 0.
  - Every voice whose rank was below the target's old rank increments by 1.
  - Ranks stay a permutation of 0..VOICES-1.
- **Note-off**
  - If `hit` exists, clear that voice's gate. Note and rank are unchanged, with no trig.
  - Otherwise (note-off for a stolen or unknown note) the event is ignored silently.
- **Reset values**: all gates 0, all notes 0, trig 0, `busy` 0, `dropped` 0, `pend_valid` 0, rank[i] = i, FSM IDLE, synchronizer flops 0.
- **Reset mid-operation**: the in-flight event and the pending event are discarded, with no partial update.

## Timing

- Let E0 be the first `clk` edge at which `clk_msg` is sampled high.
  - E1: synchronizer stage 2 is high.
  - E2: edge detected, `pend_valid` set.
  - E3: IDLE→SCAN (`busy` rises).
  - SCAN occupies E4..E(3+VOICES).
  - COMMIT's edge E(4+VOICES) updates gate, note and trig; `busy` falls at the same edge.
- With VOICES = 4, outputs change at E8. `voice_trig` is high from E8 to E9.
- Throughput is one event per VOICES+2 cycles. The scanner's event spacing (≥ clk/1300) never fills the pending slot in normal use.
- A `clk_msg` high level lasting many cycles yields exactly one event. A new event requires a low sample first.

## Structure

- Shared package `piano_pkg` holds:
  - `MSG_ON_BIT` = 7 and `NOTE_W` = 7;
  - the FSM state enum (IDLE/SCAN/COMMIT);
  - a `note_event_t` struct {on, note}.
- One sub-module, `sync_edge`: 2-flop synchronizer plus rising-edge pulse, with ports `clk`, `rst`, `d` and `rise`.

## Test plan

- **Reset then single on**: `msg` = 0x80|60 → voice 0 gate = 1, note = 60, trig[0] pulses once, exactly at E8 (VOICES = 4).
- **Fill pool and steal**: notes 60, 62, 64, 65 on, then 67 on → 67 replaces voice 0 (60, oldest). Ranks afterwards: v0 = 0, v3 = 1, v2 = 2, v1 = 3.
- **Retrigger and off**: 60 on, 60 on again → same voice 0 retriggered with 2 trig pulses, still one gate. Then 60 off → gate[0] = 0, note stays 60.
- **Stale note-off**: after the steal scenario, 60 off → no output change, no trig.
- **Overflow**: three `clk_msg` rises 3 cycles apart → the first two are processed in order, the third causes `dropped` = 1 for one cycle.
- **Reset mid-SCAN**: assert `rst` while `busy` = 1 → all outputs at reset values next cycle. After release, a fresh 0x80|48 lands in voice 0.
